// File: rtl/i2c_target.sv
// Write-only I2C target: captures a two-byte word addressed to DEVADDR and commits it on STOP.
// Optional define I2C_TARGET_FILTER_EN adds a 3-sample majority filter on both synchronized lines.
module i2c_target #(
  parameter logic [6:0] DEVADDR = 7'h1a
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] wdata,
  output logic        wvalid,
  output logic        busy,
  output logic [7:0]  wcount
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, BYTE0, ACK0, BYTE1, ACK1, WAIT_STOP, IGNORE
  } state_t;

  logic [1:0] sck_sync_q, sck_sync_d, sda_sync_q, sda_sync_d;
  logic       sck_prev_q, sck_prev_d, sda_prev_q, sda_prev_d;
  logic       sck_l, sda_l;

`ifdef I2C_TARGET_FILTER_EN
  logic [2:0] sck_hist_q, sck_hist_d, sda_hist_q, sda_hist_d;

  always_comb begin
    sck_hist_d = {sck_hist_q[1:0], sck_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_hist_q <= 3'b000;
      sda_hist_q <= 3'b000;
    end else begin
      sck_hist_q <= sck_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign sck_l = (sck_hist_q[0] & sck_hist_q[1]) | (sck_hist_q[0] & sck_hist_q[2]) |
                 (sck_hist_q[1] & sck_hist_q[2]);
  assign sda_l = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                 (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign sck_l = sck_sync_q[1];
  assign sda_l = sda_sync_q[1];
`endif

  always_comb begin
    sck_sync_d = {sck_sync_q[0], sck};
    sda_sync_d = {sda_sync_q[0], sda_in};
    sck_prev_d = sck_l;
    sda_prev_d = sda_l;
  end

  logic sck_rise, sck_fall, start_det, stop_det;
  assign sck_rise  = sck_l & ~sck_prev_q;
  assign sck_fall  = ~sck_l & sck_prev_q;
  assign start_det = sck_l & sck_prev_q & sda_prev_q & ~sda_l;
  assign stop_det  = sck_l & sck_prev_q & ~sda_prev_q & sda_l;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [15:0] stage_q, stage_d;
  logic        ready_q, ready_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wvalid_q, wvalid_d;
  logic [7:0]  wcount_q, wcount_d;
  logic [7:0]  byte_now;

  assign byte_now = {shift_q, sda_l};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    stage_d  = stage_q;
    ready_d  = ready_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    wcount_d = wcount_q;
    if (start_det || stop_det) begin
      // ready_q marks a word whose second ACK has completed; it survives into IGNORE
      if (ready_q) begin
        wdata_d  = stage_q;
        wvalid_d = 1'b1;
        wcount_d = wcount_q + 8'd1;
      end
      ready_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 3'd0;
      stage_d  = 16'h0000;
      state_d  = start_det ? ADDR : IDLE;
    end else begin
      case (state_q)
        ADDR, BYTE0, BYTE1, WAIT_STOP: begin
          if (sck_rise) begin
            shift_d = byte_now[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              case (state_q)
                ADDR: begin
                  if (byte_now == {DEVADDR, 1'b0}) begin
                    state_d = ADDR_ACK;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = IGNORE;
                  end
                end
                BYTE0: begin
                  stage_d[15:8] = byte_now;
                  state_d       = ACK0;
                end
                BYTE1: begin
                  stage_d[7:0] = byte_now;
                  state_d      = ACK1;
                end
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR_ACK, ACK0, ACK1: begin
          // first falling edge drives the ACK bit, the second one releases it
          if (sck_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              case (state_q)
                ADDR_ACK: state_d = BYTE0;
                ACK0:     state_d = BYTE1;
                default: begin
                  state_d = WAIT_STOP;
                  ready_d = 1'b1;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= 2'b00;
      sda_sync_q <= 2'b00;
      sck_prev_q <= 1'b0;
      sda_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      stage_q    <= 16'h0000;
      ready_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wdata_q    <= 16'h0000;
      wvalid_q   <= 1'b0;
      wcount_q   <= 8'h00;
    end else begin
      sck_sync_q <= sck_sync_d;
      sda_sync_q <= sda_sync_d;
      sck_prev_q <= sck_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      wcount_q   <= wcount_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign wdata  = wdata_q;
  assign wvalid = wvalid_q;
  assign busy   = busy_q;
  assign wcount = wcount_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C initiator with a transaction-level expectation model.
module tb_i2c_target;
  localparam logic [6:0] DEVADDR = 7'h1a;
`ifdef I2C_TARGET_FILTER_EN
  localparam int L1 = 3, L2 = 3, H = 4, LAT_MAX = 6;
`else
  localparam int L1 = 2, L2 = 2, H = 4, LAT_MAX = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b1;
  logic        sda_drv = 1'b1;
  logic        sda_in, sda_oe, wvalid, busy;
  logic [15:0] wdata;
  logic [7:0]  wcount;

  always #5 clk = ~clk;
  // open-drain bus: the target can only pull the line low
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target #(.DEVADDR(DEVADDR)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sda_in(sda_in), .sda_oe(sda_oe),
    .wdata(wdata), .wvalid(wvalid), .busy(busy), .wcount(wcount)
  );

  int n_checks = 0;
  int n_pass = 0;

  // monitors: running counters only, tests compare deltas
  int          wv_cnt = 0, wv_wide = 0, busy_cnt = 0, oe_bad = 0;
  logic        wv_prev = 1'b0;
  logic        in_ack = 1'b0;
  always @(negedge clk) begin
    if (wvalid) wv_cnt <= wv_cnt + 1;
    if (wvalid && wv_prev) wv_wide <= wv_wide + 1;
    wv_prev <= wvalid;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (sck && sda_oe && !in_ack) oe_bad <= oe_bad + 1;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1);
  end

  // segment = bytes following one START (address byte first)
  logic [7:0]  seg_b [0:7];
  int          seg_n;
  logic        obs_ack [0:7];
  logic        obs_busy;
  int          glitch_byte = -1;
  logic        glitch_en = 1'b0;
  int          stop_lat;

  // reference model
  int          exp_wcount = 0;
  logic [15:0] exp_wdata = 16'h0000;
  int          exp_wv = 0;

  function automatic bit m_match();
    return seg_b[0] == {DEVADDR, 1'b0};
  endfunction
  function automatic bit m_ack(input int i);
    return m_match() && i <= 2;
  endfunction
  function automatic bit m_commit();
    return m_match() && seg_n >= 3;
  endfunction
  task automatic model_end_seg();
    if (m_commit()) begin
      exp_wcount = (exp_wcount + 1) % 256;
      exp_wdata  = {seg_b[1], seg_b[2]};
      exp_wv     = exp_wv + 1;
    end
  endtask
  task automatic model_reset();
    exp_wcount = 0;
    exp_wdata  = 16'h0000;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ticks(L1); sda_drv = b; ticks(L2); sck = 1'b1;
    if (glitch_en) begin
      ticks(H / 2); sda_drv = ~b; ticks(1); sda_drv = b; ticks(H - H / 2 - 1);
    end else begin
      ticks(H);
    end
    sck = 1'b0;
  endtask

  task automatic ack_slot(output logic ack);
    in_ack = 1'b1;
    ticks(L1); sda_drv = 1'b1; ticks(L2); sck = 1'b1;
    ticks(H / 2); ack = sda_oe; ticks(H - H / 2);
    sck = 1'b0;
    in_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
    ack_slot(ack);
  endtask

  task automatic run_segment(input bit rep);
    if (rep) begin
      ticks(L1); sda_drv = 1'b1; ticks(L2); sck = 1'b1; ticks(H);
      sda_drv = 1'b0; ticks(H); sck = 1'b0;
    end else begin
      sda_drv = 1'b0; ticks(H); sck = 1'b0;
    end
    for (int i = 0; i < seg_n; i++) begin
      glitch_en = (i == glitch_byte);
      send_byte(seg_b[i], obs_ack[i]);
      glitch_en = 1'b0;
    end
    obs_busy = busy;
  endtask

  task automatic stop_bus();
    ticks(L1); sda_drv = 1'b0; ticks(L2); sck = 1'b1; ticks(H);
    sda_drv = 1'b1;
    stop_lat = -1;
    for (int i = 0; i < 2 * H + 2; i++) begin
      ticks(1);
      if (wvalid && stop_lat < 0) stop_lat = i + 1;
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    seg_b[0] = a; seg_b[1] = b; seg_b[2] = c; seg_n = n;
  endtask

  task automatic test_reset();
    reset = 1'b1; ticks(4);
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (wdata !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", wdata); else n_pass++;
    n_checks++; if (wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b want 0", wvalid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wcount !== 8'h00) $display("FAIL reset_wcount: got %h want 00", wcount); else n_pass++;
    reset = 1'b0; ticks(6);
    model_reset();
  endtask

  task automatic test_basic_write();
    int wv0;
    wv0 = wv_cnt;
    load(8'h34, 8'h0F, 8'h00, 3);
    run_segment(1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_ack[i] !== m_ack(i)) $display("FAIL basic_ack[%0d]: got %b want %b", i, obs_ack[i], m_ack(i));
      else n_pass++;
    end
    n_checks++; if (obs_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", obs_busy); else n_pass++;
    model_end_seg();
    stop_bus();
    n_checks++; if (wv_cnt - wv0 != 1) $display("FAIL basic_wvalid_count: got %0d want 1", wv_cnt - wv0); else n_pass++;
    n_checks++;
    if (stop_lat < 1 || stop_lat > LAT_MAX) $display("FAIL basic_wvalid_latency: got %0d want 1..%0d", stop_lat, LAT_MAX);
    else n_pass++;
    n_checks++; if (wdata !== 16'h0F00) $display("FAIL basic_wdata: got %h want 0f00", wdata); else n_pass++;
    n_checks++; if (wcount !== 8'(exp_wcount)) $display("FAIL basic_wcount: got %h want %h", wcount, 8'(exp_wcount)); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrong_addr();
    int wv0, b0;
    wv0 = wv_cnt; b0 = busy_cnt;
    load(8'h36, 8'h04, 8'h08, 3);
    run_segment(1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_ack[i] !== m_ack(i)) $display("FAIL wrongaddr_ack[%0d]: got %b want %b", i, obs_ack[i], m_ack(i));
      else n_pass++;
    end
    model_end_seg();
    stop_bus();
    n_checks++; if (wv_cnt != wv0) $display("FAIL wrongaddr_wvalid: got %0d pulses want 0", wv_cnt - wv0); else n_pass++;
    n_checks++; if (busy_cnt != b0) $display("FAIL wrongaddr_busy: got %0d busy cycles want 0", busy_cnt - b0); else n_pass++;
  endtask

  task automatic test_read();
    int wv0;
    wv0 = wv_cnt;
    load(8'h35, 8'hA5, 8'h00, 2);
    run_segment(1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_ack[i] !== 1'b0) $display("FAIL read_ack[%0d]: got %b want 0", i, obs_ack[i]);
      else n_pass++;
    end
    model_end_seg();
    stop_bus();
    n_checks++; if (wv_cnt != wv0) $display("FAIL read_wvalid: got %0d pulses want 0", wv_cnt - wv0); else n_pass++;
    n_checks++; if (wcount !== 8'(exp_wcount)) $display("FAIL read_wcount: got %h want %h", wcount, 8'(exp_wcount)); else n_pass++;
  endtask

  task automatic test_rep_start();
    int wv0;
    wv0 = wv_cnt;
    load(8'h34, 8'h04, 8'h00, 2);
    run_segment(1'b0);
    n_checks++; if (obs_ack[1] !== 1'b1) $display("FAIL repstart_first_ack: got %b want 1", obs_ack[1]); else n_pass++;
    model_end_seg();
    load(8'h34, 8'h04, 8'h08, 3);
    run_segment(1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_ack[i] !== 1'b1) $display("FAIL repstart_ack[%0d]: got %b want 1", i, obs_ack[i]);
      else n_pass++;
    end
    model_end_seg();
    stop_bus();
    n_checks++; if (wv_cnt - wv0 != 1) $display("FAIL repstart_wvalid: got %0d want 1", wv_cnt - wv0); else n_pass++;
    n_checks++; if (wdata !== 16'h0408) $display("FAIL repstart_wdata: got %h want 0408", wdata); else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int wv0, nseg;
      wv0 = wv_cnt;
      exp_wv = 0;
      nseg = $urandom_range(1, 2);
      for (int s = 0; s < nseg; s++) begin
        case ($urandom_range(0, 3))
          0, 1:    seg_b[0] = 8'h34;
          2:       seg_b[0] = 8'h35;
          default: seg_b[0] = 8'h36;
        endcase
        seg_n = 1 + $urandom_range(1, 4);
        for (int i = 1; i < seg_n; i++) seg_b[i] = 8'($urandom);
        run_segment(s > 0);
        for (int i = 0; i < seg_n; i++) begin
          n_checks++;
          if (obs_ack[i] !== m_ack(i))
            $display("FAIL random_ack t%0d s%0d b%0d: got %b want %b", t, s, i, obs_ack[i], m_ack(i));
          else n_pass++;
        end
        n_checks++;
        if (obs_busy !== m_match()) $display("FAIL random_busy t%0d s%0d: got %b want %b", t, s, obs_busy, m_match());
        else n_pass++;
        model_end_seg();
      end
      stop_bus();
      n_checks++; if (wv_cnt - wv0 != exp_wv) $display("FAIL random_wvalid t%0d: got %0d want %0d", t, wv_cnt - wv0, exp_wv); else n_pass++;
      n_checks++; if (wdata !== exp_wdata) $display("FAIL random_wdata t%0d: got %h want %h", t, wdata, exp_wdata); else n_pass++;
      n_checks++; if (wcount !== 8'(exp_wcount)) $display("FAIL random_wcount t%0d: got %h want %h", t, wcount, 8'(exp_wcount)); else n_pass++;
    end
  endtask

`ifdef I2C_TARGET_FILTER_EN
  task automatic test_glitch();
    int wv0;
    wv0 = wv_cnt;
    load(8'h34, 8'h04, 8'h08, 3);
    glitch_byte = 1;
    run_segment(1'b0);
    glitch_byte = -1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_ack[i] !== 1'b1) $display("FAIL glitch_ack[%0d]: got %b want 1", i, obs_ack[i]);
      else n_pass++;
    end
    model_end_seg();
    stop_bus();
    n_checks++; if (wv_cnt - wv0 != 1) $display("FAIL glitch_wvalid: got %0d want 1", wv_cnt - wv0); else n_pass++;
    n_checks++; if (wdata !== 16'h0408) $display("FAIL glitch_wdata: got %h want 0408", wdata); else n_pass++;
  endtask
`endif

  task automatic test_wrap_and_reset();
    int wv0, b0;
    logic ack;
    reset = 1'b1; ticks(3); reset = 1'b0; ticks(6);
    model_reset();
    wv0 = wv_cnt;
    for (int n = 0; n < 256; n++) begin
      load(8'h34, 8'($urandom), 8'($urandom), 3);
      run_segment(1'b0);
      model_end_seg();
      stop_bus();
      if (n == 254) begin
        n_checks++; if (wcount !== 8'hFF) $display("FAIL wrap_wcount_ff: got %h want ff", wcount); else n_pass++;
      end
    end
    n_checks++; if (wcount !== 8'h00) $display("FAIL wrap_wcount_00: got %h want 00", wcount); else n_pass++;
    n_checks++; if (wv_cnt - wv0 != 256) $display("FAIL wrap_wvalid_count: got %0d want 256", wv_cnt - wv0); else n_pass++;
    n_checks++; if (wdata !== exp_wdata) $display("FAIL wrap_wdata: got %h want %h", wdata, exp_wdata); else n_pass++;
    n_checks++; if (wv_wide != 0) $display("FAIL wvalid_width: got %0d wide pulses want 0", wv_wide); else n_pass++;
    // a further write is cut by reset right after its first data byte
    wv0 = wv_cnt;
    load(8'h34, 8'h04, 8'h00, 2);
    run_segment(1'b0);
    reset = 1'b1; ticks(3);
    model_reset();
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL midreset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wdata !== 16'h0000) $display("FAIL midreset_wdata: got %h want 0000", wdata); else n_pass++;
    n_checks++; if (wcount !== 8'h00) $display("FAIL midreset_wcount: got %h want 00", wcount); else n_pass++;
    reset = 1'b0; ticks(2);
    b0 = busy_cnt;
    send_byte(8'h08, ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL midreset_no_ack: got %b want 0", ack); else n_pass++;
    stop_bus();
    n_checks++; if (wv_cnt != wv0) $display("FAIL midreset_no_commit: got %0d pulses want 0", wv_cnt - wv0); else n_pass++;
    n_checks++; if (busy_cnt != b0) $display("FAIL midreset_busy_after: got %0d busy cycles want 0", busy_cnt - b0); else n_pass++;
    n_checks++; if (wcount !== 8'(exp_wcount)) $display("FAIL midreset_wcount_after: got %h want %h", wcount, 8'(exp_wcount)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_read();
    test_rep_start();
    test_random();
`ifdef I2C_TARGET_FILTER_EN
    test_glitch();
`endif
    test_wrap_and_reset();
    n_checks++; if (oe_bad != 0) $display("FAIL sda_oe_while_sck_high: got %0d cycles want 0", oe_bad); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
